// File: rtl/bcd_updown_counter.sv
// ============================================================================
// bcd_updown_counter
// ----------------------------------------------------------------------------
// Multi-digit BCD up/down counter with count enable, parallel load, a
// registered terminal-count pulse and a registered illegal-load pulse.
// The count range is 0 .. 10^DIGITS - 1, one BCD digit per nibble, with
// digit 0 in the least significant nibble.
//
// Edge priority, highest first: Rst low, Load, En, hold.
//
// Parameters
//   DIGITS   number of cascaded BCD digits (default 2)
//
// Ports
//   Clk      in   1          rising-edge clock
//   Rst      in   1          synchronous reset, active low
//   En       in   1          count enable, one step per enabled edge
//   Up       in   1          direction: 1 = increment, 0 = decrement
//   Load     in   1          parallel load request
//   D        in   4*DIGITS   load value, BCD
//   Q        out  4*DIGITS   current count, BCD
//   Tc       out  1          terminal-count pulse (registered)
//   LoadErr  out  1          pulse when a load carried a non-BCD digit
//
// Build option
//   BCD_SATURATE_EN  when defined, the count pins at all-9s (up) or all-0s
//                    (down) instead of wrapping; Tc is high for every enabled
//                    edge spent pinned at the limit in the counting direction.
//                    When undefined, the count wraps and Tc marks the wrap.
// ============================================================================
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Tc,
    output logic                  LoadErr
);

    localparam int W = 4 * DIGITS;

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [W-1:0]      q_reg;
    logic [W-1:0]      q_next;
    logic              tc_reg;
    logic              tc_next;
    logic              load_err_reg;
    logic              load_err_next;

    // Per-digit candidates for a one-step increment and decrement
    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;

    // Per-digit flags
    logic [DIGITS-1:0] digit_nine;    // current digit is 9
    logic [DIGITS-1:0] digit_zero;    // current digit is 0
    logic [DIGITS-1:0] d_legal;       // load digit is a valid BCD digit

    logic              load_ok;
    logic              at_max;
    logic              at_min;

    // ------------------------------------------------------------------------
    // Digit chain
    // ------------------------------------------------------------------------
    // Each digit steps only when every lower digit is at its limit (9 going
    // up, 0 going down). The carry/borrow into digit i is computed as an AND
    // over the lower digit flags with a mask, so no signal feeds back into
    // itself along the chain.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            localparam logic [DIGITS-1:0] LOWER_MASK =
                {DIGITS{1'b1}} >> (DIGITS - i);

            logic [3:0] cur;
            logic [3:0] din;
            logic [3:0] inc_d;
            logic [3:0] dec_d;
            logic       carry_in;
            logic       borrow_in;

            assign cur = q_reg[4*i +: 4];
            assign din = D[4*i +: 4];

            assign digit_nine[i] = (cur == 4'd9);
            assign digit_zero[i] = (cur == 4'd0);
            assign d_legal[i]    = (din <= 4'd9);

            // Digit 0 always receives the step (empty mask -> all ones).
            assign carry_in  = &(digit_nine | ~LOWER_MASK);
            assign borrow_in = &(digit_zero | ~LOWER_MASK);

            // NOTE: every variable written in always_comb gets a default
            // first, so no path leaves it unassigned and no latch is inferred.
            always_comb begin
                inc_d = cur;
                dec_d = cur;
                if (carry_in) begin
                    inc_d = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
                end
                if (borrow_in) begin
                    dec_d = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
                end
            end

            assign inc_val[4*i +: 4] = inc_d;
            assign dec_val[4*i +: 4] = dec_d;

            // A digit outside 0..9 is unreachable from reset and legal loads.
            assert property (@(posedge Clk) disable iff (!Rst) cur <= 4'd9)
                else $error("non-BCD digit %0d in Q", i);
        end
    endgenerate

    // The whole count sits at a limit when every digit does.
    assign at_max  = &digit_nine;
    assign at_min  = &digit_zero;

    // A load is all-or-nothing: a single bad digit rejects the whole word.
    assign load_ok = &d_legal;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        q_next        = q_reg;
        tc_next       = 1'b0;
        load_err_next = 1'b0;

        if (Load) begin
            // En is ignored on a load cycle, legal or not.
            if (load_ok) begin
                q_next = D;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (En) begin
            if (Up) begin
                // inc_val is already all zeros when the count is all 9s.
                q_next  = inc_val;
                tc_next = at_max;
`ifdef BCD_SATURATE_EN
                if (at_max) begin
                    q_next = q_reg;
                end
`endif
            end else begin
                // dec_val is already all 9s when the count is all zeros.
                q_next  = dec_val;
                tc_next = at_min;
`ifdef BCD_SATURATE_EN
                if (at_min) begin
                    q_next = q_reg;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            q_reg        <= '0;
            tc_reg       <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            q_reg        <= q_next;
            tc_reg       <= tc_next;
            load_err_reg <= load_err_next;
        end
    end

    // Tc comes only from counting and LoadErr only from loading, and the two
    // are mutually exclusive by priority.
    assert property (@(posedge Clk) !(tc_reg && load_err_reg))
        else $error("Tc and LoadErr high together");

    // ------------------------------------------------------------------------
    // Outputs: straight from registers, no combinational input-to-output path
    // ------------------------------------------------------------------------
    assign Q       = q_reg;
    assign Tc      = tc_reg;
    assign LoadErr = load_err_reg;

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Multi-digit BCD up/down counter with enable, parallel load and terminal-count pulse. It is the bidirectional decimal member of the counter family: it counts up or down per cycle and wraps or saturates at the decade boundaries. It feeds display and timing blocks that need a decimal count value and an event flag when the count rolls over.

## Interface
Parameters:
- DIGITS, default 2: number of cascaded BCD digits; the count range is 0 to 10^DIGITS − 1.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-low. Sampled on the Clk rising edge.
- En  input  1  count enable; one step per enabled cycle.
- Up  input  1  direction: 1 = increment, 0 = decrement. Sampled every cycle.
- Load  input  1  parallel load request.
- D  input  4*DIGITS  load value; digit i is at D[4i+3:4i], and digit 0 is the least significant.
- Q  output  4*DIGITS  current count, BCD, same digit packing as D.
- Tc  output  1  terminal-count pulse, registered.
- LoadErr  output  1  illegal-load pulse, registered.

## Operation
- Priority at each rising edge, highest first: Rst low, then Load, then En, then hold.
- Reset (Rst = 0): Q = 0, Tc = 0, LoadErr = 0.
- Load = 1, all digits of D ≤ 9:
  - Q ← D.
  - Tc = 0, LoadErr = 0.
  - En is ignored that cycle.
- Load = 1, any digit of D > 9:
  - Q holds.
  - LoadErr = 1 for that cycle only; Tc = 0.
  - No partial load.
  - En is ignored that cycle.
- Load = 0, En = 1, Up = 1:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - A digit below 9 increments and stops the carry chain.
- Load = 0, En = 1, Up = 0:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - A digit above 0 decrements and stops the borrow chain.
- Wrap (default build):
  - All digits 9 counting up → all digits 0; Tc = 1 for that cycle.
  - All digits 0 counting down → all digits 9; Tc = 1 for that cycle.
- En = 0 with Load = 0: Q holds, Tc = 0, LoadErr = 0.
- Tc and LoadErr are never high at the same time.
- Q never holds a non-BCD digit. Such a value is unreachable from reset and legal loads.
- The digit chain is built with a generate loop over DIGITS. There is no hard-coded width.

## Timing
- Q, Tc and LoadErr are all registered. There is no combinational path from any input to any output.
- Latency: an input sampled at edge N appears on Q, Tc and LoadErr after edge N. Tc and LoadErr are high for exactly the one cycle following edge N.
- A direction change applies on the next enabled edge. There is no dead cycle.
- Back-to-back wraps (DIGITS = 1, toggling around 9/0) give a Tc pulse on every wrapping edge.
- Rst low mid-count overrides Load and En on the same edge. Counting resumes from 0 on the first edge with Rst high.

## Configuration
- BCD_SATURATE_EN defined:
  - Counting up from all-9s holds Q at all-9s.
  - Counting down from all-0s holds Q at 0.
  - Tc = 1 for each enabled cycle spent pinned at the limit in the counting direction.
  - Leaving the limit (reversing direction) clears Tc on the next edge.
- BCD_SATURATE_EN undefined: wrap behaviour as described under Operation.
- Load, reset and LoadErr behaviour are identical in both builds.

## Test plan
- Reset: hold Rst = 0 for 2 cycles with En = 1, Load = 1, D = 0x55 → Q = 0x00, Tc = 0, LoadErr = 0.
- Up wrap (DIGITS = 2): from reset, En = 1, Up = 1 for 100 cycles → Q steps through 0x00 to 0x99 in BCD (0x09 → 0x10, never 0x0A) and returns to 0x00. Tc is high only in the cycle Q becomes 0x00.
- Down wrap and load: load D = 0x47, then En = 1, Up = 0 → Q sequence 0x47, 0x46 … 0x40, 0x39 … 0x00, 0x99. Tc is high only with Q = 0x99.
- Illegal load: Q = 0x12, Load = 1, D = 0x3A → Q stays 0x12 and LoadErr pulses for 1 cycle. A following load of D = 0x38 gives Q = 0x38 with LoadErr = 0.
- Simultaneous events: Load = 1, D = 0x20 with En = 1, Up = 1 → Q = 0x20, not 0x21. Rst = 0 with Load = 1 → Q = 0x00.
- BCD_SATURATE_EN build: load 0x98, En = 1, Up = 1 for 3 cycles → Q = 0x99, 0x99, 0x99 with Tc = 0, 1, 1. Then Up = 0 → Q = 0x98 and Tc = 0.
